// File: rtl/button_conditioner.sv
// Multi-channel button debouncer: two-flop synchronizer, per-channel stability
// counter, and registered rise/fall pulses aligned with the debounced level.
module button_conditioner #(
    parameter int W         = 4,
    parameter int COUNT_MAX = 500000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] btn_raw,
    output logic [W-1:0] btn_clean,
    output logic [W-1:0] btn_rise,
    output logic [W-1:0] btn_fall
);

    localparam int               CNT_W    = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [W-1:0]     r_sync1;
    logic [W-1:0]     r_sync2;
    logic [W-1:0]     r_clean;
    logic [W-1:0]     r_rise;
    logic [W-1:0]     r_fall;
    logic [CNT_W-1:0] r_cnt [W];

    logic [W-1:0]     w_diff;
    logic [W-1:0]     w_accept;

    // Synchronizer stage: nothing downstream sees btn_raw directly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // A channel is accepted once it has disagreed with btn_clean for COUNT_MAX cycles
    always_comb begin
        w_diff   = r_sync2 ^ r_clean;
        w_accept = '0;
        for (int i = 0; i < W; i++) begin
            w_accept[i] = w_diff[i] && (r_cnt[i] == CNT_LAST);
        end
    end

    for (genvar g = 0; g < W; g++) begin : g_cnt
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt[g] <= '0;
            end else if (!w_diff[g] || w_accept[g]) begin
                r_cnt[g] <= '0;
            end else begin
                r_cnt[g] <= r_cnt[g] + CNT_ONE;
            end
        end
    end

    // Pulses are registered on the same edge as the level so they coincide with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clean <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            r_clean <= r_clean ^ w_accept;
            r_rise  <= w_accept & r_sync2;
            r_fall  <= w_accept & ~r_sync2;
        end
    end

    assign btn_clean = r_clean;
    assign btn_rise  = r_rise;
    assign btn_fall  = r_fall;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected outputs are queued as each
// stimulus cycle is driven and compared after the following clock edge.
module tb_button_conditioner;

    localparam int W  = 4;
    localparam int CM = 4;

    logic         clk     = 1'b0;
    logic         reset   = 1'b1;
    logic [W-1:0] btn_raw = '0;
    logic [W-1:0] btn_clean;
    logic [W-1:0] btn_rise;
    logic [W-1:0] btn_fall;

    typedef struct {
        string          tag;
        logic [3*W-1:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    button_conditioner #(.W(W), .COUNT_MAX(CM)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_clean (btn_clean),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic compare_one();
        exp_t           e;
        logic [3*W-1:0] obs;
        obs = {btn_clean, btn_rise, btn_fall};
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL sb_empty: observed %b with no expected entry queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s: clean_rise_fall got %b_%b_%b expected %b_%b_%b", e.tag,
                       obs[3*W-1:2*W], obs[2*W-1:W], obs[W-1:0],
                       e.val[3*W-1:2*W], e.val[2*W-1:W], e.val[W-1:0]);
            end
        end
    endtask

    task automatic check_now(input logic [W-1:0] c, input logic [W-1:0] r,
                             input logic [W-1:0] f, input string tag);
        sb.push_back('{tag, {c, r, f}});
        compare_one();
    endtask

    task automatic cyc(input logic [W-1:0] raw, input logic [W-1:0] c,
                       input logic [W-1:0] r, input logic [W-1:0] f, input string tag);
        btn_raw = raw;
        sb.push_back('{tag, {c, r, f}});
        @(posedge clk);
        #1;
        compare_one();
    endtask

    // Hold raw stable: level unchanged for CM+1 edges, new level and pulse on edge CM+2
    task automatic accept(input logic [W-1:0] raw, input logic [W-1:0] old_c,
                          input logic [W-1:0] new_c, input int hold, input string tag);
        logic [W-1:0] r;
        logic [W-1:0] f;
        r = new_c & ~old_c;
        f = old_c & ~new_c;
        for (int k = 1; k <= CM + 1; k++) begin
            cyc(raw, old_c, '0, '0, $sformatf("%s_wait%0d", tag, k));
        end
        cyc(raw, new_c, r, f, {tag, "_edge"});
        for (int k = 1; k <= hold; k++) begin
            cyc(raw, new_c, '0, '0, $sformatf("%s_hold%0d", tag, k));
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            total++;
            assert ((btn_rise & btn_fall) === '0) else begin
                bad++;
                $error("FAIL rise_fall_overlap: rise=%b fall=%b required no common bit",
                       btn_rise, btn_fall);
            end
        end
    end

    initial begin
        btn_raw = '0;
        reset   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_now('0, '0, '0, "reset_state");
        reset = 1'b0;

        cyc('0, '0, '0, '0, "idle1");
        cyc('0, '0, '0, '0, "idle2");

        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 3; k++) cyc(4'b0001, '0, '0, '0, $sformatf("bounce%0d_hi%0d", b, k));
            for (int k = 0; k < 3; k++) cyc(4'b0000, '0, '0, '0, $sformatf("bounce%0d_lo%0d", b, k));
        end
        for (int k = 0; k < 3; k++) cyc(4'b0000, '0, '0, '0, $sformatf("bounce_settle%0d", k));

        accept(4'b0001, 4'b0000, 4'b0001, 5, "press0");
        accept(4'b0000, 4'b0001, 4'b0000, 3, "release0");

        for (int k = 0; k < 3; k++) cyc(4'b0100, '0, '0, '0, $sformatf("rst_pre%0d", k));
        reset = 1'b1;
        #1;
        check_now('0, '0, '0, "rst_mid_async");
        @(posedge clk);
        #1;
        check_now('0, '0, '0, "rst_mid_held");
        reset = 1'b0;
        accept(4'b0100, 4'b0000, 4'b0100, 3, "rst_release");
        accept(4'b0000, 4'b0100, 4'b0000, 3, "release2");

        accept(4'b1010, 4'b0000, 4'b1010, 14, "simul");

        reset = 1'b1;
        #1;
        check_now('0, '0, '0, "async_reset_from_set");
        @(posedge clk);
        #1;
        check_now('0, '0, '0, "reset_held_final");
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
